// File: rtl/nn_mac_accum.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nn_mac_accum : registered signed multiply + saturating dot-product accumulator.
// Optional: define MAC_RELU_EN to clamp negative results to zero.  Rev 1.0
// ---------------------------------------------------------------------------
module nn_mac_accum #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_act,
  input  logic signed [DATA_W-1:0] in_wgt,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_data,
  output logic                     out_ovf
);

  localparam int PROD_W = 2 * DATA_W;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic                     stall;
  logic                     xfer;
  logic signed [PROD_W-1:0] prod;

  logic signed [PROD_W-1:0] p1_q, p1_d;
  logic                     v1_q, v1_d;
  logic                     l1_q, l1_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     ovf_q, ovf_d;
  logic signed [ACC_W-1:0]  out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_ovf_q, out_ovf_d;

  logic signed [ACC_W:0]    sum;
  logic                     clamp_hi;
  logic                     clamp_lo;
  logic                     clamp_now;
  logic signed [ACC_W-1:0]  sat_sum;
  logic signed [ACC_W-1:0]  res;

  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~stall;
  assign xfer     = in_valid & in_ready;
  assign prod     = in_act * in_wgt;

  // One guard bit is enough: the two top bits disagree exactly on overflow.
  assign sum       = {acc_q[ACC_W-1], acc_q}
                   + {{(ACC_W+1-PROD_W){p1_q[PROD_W-1]}}, p1_q};
  assign clamp_hi  = ~sum[ACC_W] &  sum[ACC_W-1];
  assign clamp_lo  =  sum[ACC_W] & ~sum[ACC_W-1];
  assign clamp_now = clamp_hi | clamp_lo;
  assign sat_sum   = clamp_hi ? ACC_MAX : (clamp_lo ? ACC_MIN : sum[ACC_W-1:0]);

`ifdef MAC_RELU_EN
  assign res = sat_sum[ACC_W-1] ? '0 : sat_sum;
`else
  assign res = sat_sum;
`endif

  always_comb begin
    p1_d        = p1_q;
    v1_d        = v1_q;
    l1_d        = l1_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_ovf_d   = out_ovf_q;

    if (!stall) begin
      v1_d = xfer;
      if (xfer) begin
        p1_d = prod;
        l1_d = in_last;
      end
      // Not stalled means any held result is being drained this edge.
      out_valid_d = 1'b0;
      if (v1_q) begin
        if (l1_q) begin
          out_data_d  = res;
          out_ovf_d   = ovf_q | clamp_now;
          out_valid_d = 1'b1;
          acc_d       = '0;
          ovf_d       = 1'b0;
        end else begin
          acc_d = sat_sum;
          ovf_d = ovf_q | clamp_now;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_q        <= '0;
      v1_q        <= 1'b0;
      l1_q        <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      p1_q        <= p1_d;
      v1_q        <= v1_d;
      l1_q        <= l1_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule
`default_nettype wire
